// File: rtl/m_game_sequencer_pkg.sv
//------------------------------------------------------------------------------
// m_game_sequencer_pkg
// Shared state encoding, direction codes and grid coordinate widths.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package m_game_sequencer_pkg;

    localparam int X_W = 5;
    localparam int Y_W = 4;

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_LOOKUP = 3'd2,
        ST_CHECK  = 3'd3,
        ST_COMMIT = 3'd4,
        ST_RENDER = 3'd5,
        ST_OVER   = 3'd6
    } t_state;

    typedef enum logic [2:0] {
        DIR_NONE  = 3'd0,
        DIR_UP    = 3'd1,
        DIR_DOWN  = 3'd2,
        DIR_LEFT  = 3'd3,
        DIR_RIGHT = 3'd4
    } t_dir;

    // key bits are {up,down,left,right}; up wins over down over left over right
    function automatic t_dir f_dir_decode(input logic [3:0] i_key);
        t_dir v_dir;
        v_dir = DIR_NONE;
        if (i_key[3])      v_dir = DIR_UP;
        else if (i_key[2]) v_dir = DIR_DOWN;
        else if (i_key[1]) v_dir = DIR_LEFT;
        else if (i_key[0]) v_dir = DIR_RIGHT;
        return v_dir;
    endfunction

endpackage

`default_nettype wire

// File: rtl/m_game_sequencer_if.sv
//------------------------------------------------------------------------------
// m_game_sequencer_if
// Sequencer <-> renderer / wall-ROM bus: positions, render handshake, map lookup.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface m_game_sequencer_if;
    import m_game_sequencer_pkg::*;

    logic [8:0]     map_addr;
    logic           wall_q;
    logic           render_en;
    logic           render_finished;
    logic [X_W-1:0] pl_game_x;
    logic [Y_W-1:0] pl_game_y;
    logic [X_W-1:0] g1_game_x;
    logic [Y_W-1:0] g1_game_y;
    logic [X_W-1:0] g2_game_x;
    logic [Y_W-1:0] g2_game_y;
    logic [X_W-1:0] g3_game_x;
    logic [Y_W-1:0] g3_game_y;

    modport master (
        output map_addr, render_en,
        output pl_game_x, pl_game_y,
        output g1_game_x, g1_game_y, g2_game_x, g2_game_y, g3_game_x, g3_game_y,
        input  wall_q, render_finished
    );

    modport slave (
        input  map_addr, render_en,
        input  pl_game_x, pl_game_y,
        input  g1_game_x, g1_game_y, g2_game_x, g2_game_y, g3_game_x, g3_game_y,
        output wall_q, render_finished
    );

endinterface

`default_nettype wire

// File: rtl/m_game_sequencer_tick_gen.sv
//------------------------------------------------------------------------------
// m_tick_gen
// Free-running 0..TICK_CYCLES-1 counter with a one-cycle tick at wrap; freezable.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module m_tick_gen #(
    parameter int unsigned TICK_CYCLES = 2500000
) (
    input  wire logic clock,
    input  wire logic resetn,
    input  wire logic i_freeze,
    output logic      o_tick
);

    localparam int CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(TICK_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= '0;
        end else if (!i_freeze) begin
            if (r_cnt == c_LAST) r_cnt <= '0;
            else                 r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_tick = (r_cnt == c_LAST) && !i_freeze;

endmodule

`default_nettype wire

// File: rtl/m_game_sequencer.sv
//------------------------------------------------------------------------------
// m_game_sequencer
// Frame controller: game tick, wall-checked player moves, ghost snapshot,
// collision detection and renderer handshake. Optional LIVES_COUNTER_EN
// adds a 3-life counter with respawn and the lives_left output.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module m_game_sequencer
    import m_game_sequencer_pkg::*;
#(
    parameter int unsigned TICK_CYCLES = 2500000,
    parameter int unsigned GRID_W      = 32,
    parameter int unsigned GRID_H      = 16,
    parameter int unsigned PL_START_X  = 1,
    parameter int unsigned PL_START_Y  = 1
) (
    input  wire logic           clock,
    input  wire logic           resetn,
    input  wire logic [3:0]     key_dir,
    input  wire logic [X_W-1:0] g1_in_x,
    input  wire logic [X_W-1:0] g2_in_x,
    input  wire logic [X_W-1:0] g3_in_x,
    input  wire logic [Y_W-1:0] g1_in_y,
    input  wire logic [Y_W-1:0] g2_in_y,
    input  wire logic [Y_W-1:0] g3_in_y,
    output logic                game_over,
    output logic                tick_overrun,
`ifdef LIVES_COUNTER_EN
    output logic [1:0]          lives_left,
`endif
    m_game_sequencer_if.master  bus
);

    localparam logic [X_W-1:0] c_X_MAX   = X_W'(GRID_W - 1);
    localparam logic [Y_W-1:0] c_Y_MAX   = Y_W'(GRID_H - 1);
    localparam logic [X_W-1:0] c_START_X = X_W'(PL_START_X);
    localparam logic [Y_W-1:0] c_START_Y = Y_W'(PL_START_Y);

    t_state         r_state;
    t_dir           r_dir;
    logic           r_tick_pend;
    logic           r_overrun;
    logic           r_game_over;
    logic           r_render_en;
    logic           r_collide;
    logic           r_wall;
    logic [8:0]     r_map_addr;
    logic [X_W-1:0] r_pl_x, r_cand_x, r_g1_x, r_g2_x, r_g3_x;
    logic [Y_W-1:0] r_pl_y, r_cand_y, r_g1_y, r_g2_y, r_g3_y;
    logic           r_cand_ok;
`ifdef LIVES_COUNTER_EN
    logic [1:0]     r_lives;
`endif

    logic           w_tick;
    logic           w_consume;
    logic [X_W-1:0] w_cand_x, w_next_x;
    logic [Y_W-1:0] w_cand_y, w_next_y;
    logic           w_cand_ok;
    logic           w_hit;

    m_tick_gen #(
        .TICK_CYCLES (TICK_CYCLES)
    ) u_tick (
        .clock    (clock),
        .resetn   (resetn),
        .i_freeze (r_state == ST_OVER),
        .o_tick   (w_tick)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)              r_dir <= DIR_NONE;
        else if (key_dir != 4'd0) r_dir <= f_dir_decode(key_dir);
    end

    // Edge-of-grid candidates are rejected here so they never reach the ROM
    always_comb begin
        w_cand_x  = r_pl_x;
        w_cand_y  = r_pl_y;
        w_cand_ok = 1'b0;
        case (r_dir)
            DIR_UP:    if (r_pl_y != '0)     begin w_cand_y = r_pl_y - Y_W'(1); w_cand_ok = 1'b1; end
            DIR_DOWN:  if (r_pl_y < c_Y_MAX) begin w_cand_y = r_pl_y + Y_W'(1); w_cand_ok = 1'b1; end
            DIR_LEFT:  if (r_pl_x != '0)     begin w_cand_x = r_pl_x - X_W'(1); w_cand_ok = 1'b1; end
            DIR_RIGHT: if (r_pl_x < c_X_MAX) begin w_cand_x = r_pl_x + X_W'(1); w_cand_ok = 1'b1; end
            default: ;
        endcase
    end

    assign w_next_x  = (r_cand_ok && !r_wall) ? r_cand_x : r_pl_x;
    assign w_next_y  = (r_cand_ok && !r_wall) ? r_cand_y : r_pl_y;
    assign w_hit     = ((w_next_x == g1_in_x) && (w_next_y == g1_in_y)) ||
                       ((w_next_x == g2_in_x) && (w_next_y == g2_in_y)) ||
                       ((w_next_x == g3_in_x) && (w_next_y == g3_in_y));
    assign w_consume = (r_state == ST_WAIT) && r_tick_pend;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ST_INIT;
            r_tick_pend <= 1'b0;
            r_overrun   <= 1'b0;
            r_game_over <= 1'b0;
            r_render_en <= 1'b0;
            r_collide   <= 1'b0;
            r_wall      <= 1'b0;
            r_map_addr  <= '0;
            r_pl_x      <= c_START_X;
            r_pl_y      <= c_START_Y;
            r_cand_x    <= '0;
            r_cand_y    <= '0;
            r_cand_ok   <= 1'b0;
            r_g1_x      <= '0;
            r_g1_y      <= '0;
            r_g2_x      <= '0;
            r_g2_y      <= '0;
            r_g3_x      <= '0;
            r_g3_y      <= '0;
`ifdef LIVES_COUNTER_EN
            r_lives     <= 2'd3;
`endif
        end else begin
            // A fresh tick wins over the WAIT-state clear so it is never lost
            if (w_tick)         r_tick_pend <= 1'b1;
            else if (w_consume) r_tick_pend <= 1'b0;
            if (w_tick && r_tick_pend && !w_consume) r_overrun <= 1'b1;

            case (r_state)
                ST_INIT: begin
                    r_render_en <= 1'b1;
                    r_state     <= ST_RENDER;
                end
                ST_WAIT: begin
                    if (r_tick_pend) begin
                        r_cand_x  <= w_cand_x;
                        r_cand_y  <= w_cand_y;
                        r_cand_ok <= w_cand_ok;
                        if (w_cand_ok) r_map_addr <= {w_cand_y, w_cand_x};
                        r_state   <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: r_state <= ST_CHECK;
                ST_CHECK: begin
                    r_wall  <= bus.wall_q;
                    r_state <= ST_COMMIT;
                end
                ST_COMMIT: begin
                    r_pl_x <= w_next_x;
                    r_pl_y <= w_next_y;
                    r_g1_x <= g1_in_x;
                    r_g1_y <= g1_in_y;
                    r_g2_x <= g2_in_x;
                    r_g2_y <= g2_in_y;
                    r_g3_x <= g3_in_x;
                    r_g3_y <= g3_in_y;
`ifdef LIVES_COUNTER_EN
                    r_collide <= 1'b0;
                    if (w_hit) begin
                        r_lives <= r_lives - 2'd1;
                        if (r_lives != 2'd1) begin
                            r_pl_x <= c_START_X;
                            r_pl_y <= c_START_Y;
                        end else begin
                            r_collide <= 1'b1;
                        end
                    end
`else
                    r_collide <= w_hit;
`endif
                    r_render_en <= 1'b1;
                    r_state     <= ST_RENDER;
                end
                ST_RENDER: begin
                    if (bus.render_finished) begin
                        r_render_en <= 1'b0;
                        if (r_collide) begin
                            r_game_over <= 1'b1;
                            r_state     <= ST_OVER;
                        end else begin
                            r_state     <= ST_WAIT;
                        end
                    end
                end
                ST_OVER: r_render_en <= 1'b0;
                default: r_state <= ST_INIT;
            endcase
        end
    end

    assign bus.map_addr  = r_map_addr;
    assign bus.render_en = r_render_en;
    assign bus.pl_game_x = r_pl_x;
    assign bus.pl_game_y = r_pl_y;
    assign bus.g1_game_x = r_g1_x;
    assign bus.g1_game_y = r_g1_y;
    assign bus.g2_game_x = r_g2_x;
    assign bus.g2_game_y = r_g2_y;
    assign bus.g3_game_x = r_g3_x;
    assign bus.g3_game_y = r_g3_y;
    assign game_over     = r_game_over;
    assign tick_overrun  = r_overrun;
`ifdef LIVES_COUNTER_EN
    assign lives_left    = r_lives;
`endif

endmodule

`default_nettype wire

// File: tb/tb_m_game_sequencer.sv
//------------------------------------------------------------------------------
// tb_m_game_sequencer
// Directed bench: moves, boundaries, walls, ghost snapshot, collision, overrun.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_m_game_sequencer;
    import m_game_sequencer_pkg::*;

    logic           clock = 1'b0;
    logic           resetn = 1'b0;
    logic [3:0]     key_dir = 4'd0;
    logic [X_W-1:0] g1_in_x = 5'd20, g2_in_x = 5'd21, g3_in_x = 5'd22;
    logic [Y_W-1:0] g1_in_y = 4'd10, g2_in_y = 4'd10, g3_in_y = 4'd10;
    logic           game_over, tick_overrun;
    logic           wall_mem [0:511];
    int             cyc;
    int             n_cmp = 0;
    int             n_err = 0;

    m_game_sequencer_if bus ();

    m_game_sequencer #(
        .TICK_CYCLES (8),
        .GRID_W      (32),
        .GRID_H      (16),
        .PL_START_X  (1),
        .PL_START_Y  (1)
    ) dut (
        .clock        (clock),
        .resetn       (resetn),
        .key_dir      (key_dir),
        .g1_in_x      (g1_in_x),
        .g2_in_x      (g2_in_x),
        .g3_in_x      (g3_in_x),
        .g1_in_y      (g1_in_y),
        .g2_in_y      (g2_in_y),
        .g3_in_y      (g3_in_y),
        .game_over    (game_over),
        .tick_overrun (tick_overrun),
        .bus          (bus)
    );

    always #5 clock = ~clock;

    // Posedges since reset release; the tick counter mirrors cyc mod 8
    always @(posedge clock or negedge resetn) begin
        if (!resetn) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    always @(posedge clock) bus.wall_q <= wall_mem[bus.map_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        resetn = 1'b0;
        bus.render_finished = 1'b0;
        repeat (2) @(negedge clock);
        resetn = 1'b1;
    endtask

    task automatic wait_rise(output int rise_cyc);
        bit ok;
        ok = 1'b0;
        rise_cyc = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (bus.render_en) begin
                ok = 1'b1;
                rise_cyc = cyc;
                break;
            end
        end
        chk("render_rise_timeout", ok, 1'b1);
    endtask

    task automatic finish_render();
        bit ok;
        ok = 1'b0;
        bus.render_finished = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (!bus.render_en) begin
                ok = 1'b1;
                break;
            end
        end
        bus.render_finished = 1'b0;
        chk("render_fall_timeout", ok, 1'b1);
    endtask

    task automatic frame(input string tag, input bit lat, input int ex, input int ey);
        int rc;
        wait_rise(rc);
        if (lat) chk({tag, "_latency"}, rc % 8, 4);
        chk({tag, "_px"}, bus.pl_game_x, ex);
        chk({tag, "_py"}, bus.pl_game_y, ey);
        finish_render();
    endtask

    initial begin
        int rc;
        bit seen;
        for (int i = 0; i < 512; i++) wall_mem[i] = 1'b0;
        bus.render_finished = 1'b0;

        // Reset values while resetn is held low
        repeat (2) @(negedge clock);
        chk("rst_px", bus.pl_game_x, 1);
        chk("rst_py", bus.pl_game_y, 1);
        chk("rst_g1x", bus.g1_game_x, 0);
        chk("rst_g3y", bus.g3_game_y, 0);
        chk("rst_ren", bus.render_en, 0);
        chk("rst_go", game_over, 0);
        chk("rst_ovr", tick_overrun, 0);
        chk("rst_addr", bus.map_addr, 0);

        // Initial background pass, then a right move with ghost snapshot
        resetn = 1'b1;
        key_dir = 4'b0001;
        frame("init", 1'b0, 1, 1);
        chk("init_go", game_over, 0);
        wait_rise(rc);
        chk("right_latency", rc % 8, 4);
        chk("right_addr", bus.map_addr, {4'd1, 5'd2});
        chk("right_px", bus.pl_game_x, 2);
        chk("right_g1x", bus.g1_game_x, 20);
        g1_in_x = 5'd5; g1_in_y = 4'd5;
        g2_in_x = 5'd6; g2_in_y = 4'd6;
        g3_in_x = 5'd7; g3_in_y = 4'd7;
        repeat (2) @(negedge clock);
        chk("snap_hold_g1x", bus.g1_game_x, 20);
        chk("snap_hold_g2x", bus.g2_game_x, 21);
        chk("snap_hold_g3y", bus.g3_game_y, 10);
        finish_render();
        frame("right2", 1'b1, 3, 1);
        chk("snap_new_g1x", bus.g1_game_x, 5);
        chk("snap_new_g2y", bus.g2_game_y, 6);
        chk("snap_new_g3x", bus.g3_game_x, 7);

        // Top boundary, wall rejection, left boundary
        g1_in_x = 5'd20; g1_in_y = 4'd10;
        g2_in_x = 5'd21; g2_in_y = 4'd10;
        g3_in_x = 5'd22; g3_in_y = 4'd10;
        do_reset();
        key_dir = 4'b1000;
        frame("c_init", 1'b0, 1, 1);
        frame("up1", 1'b1, 1, 0);
        chk("up1_addr", bus.map_addr, 9'd1);
        frame("up_edge", 1'b1, 1, 0);
        chk("up_edge_addr", bus.map_addr, 9'd1);
        wall_mem[{4'd1, 5'd1}] = 1'b1;
        key_dir = 4'b0100;
        frame("down_wall", 1'b1, 1, 0);
        chk("down_wall_addr", bus.map_addr, {4'd1, 5'd1});
        wall_mem[{4'd1, 5'd1}] = 1'b0;
        key_dir = 4'b0010;
        frame("left1", 1'b1, 0, 0);
        frame("left_edge", 1'b1, 0, 0);
        chk("no_ovr", tick_overrun, 0);

        // Collision with ghost 2 ends the game after the frame is shown
        do_reset();
        g2_in_x = 5'd2; g2_in_y = 4'd1;
        key_dir = 4'b0001;
        frame("d_init", 1'b0, 1, 1);
        frame("hit", 1'b1, 2, 1);
        chk("hit_go", game_over, 1);
        chk("hit_ren", bus.render_en, 0);
        key_dir = 4'b0100;
        g2_in_x = 5'd9;
        seen = 1'b0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clock);
            if (bus.render_en) seen = 1'b1;
        end
        chk("over_no_render", seen, 0);
        chk("over_px", bus.pl_game_x, 2);
        chk("over_py", bus.pl_game_y, 1);
        chk("over_g2x", bus.g2_game_x, 2);
        chk("over_go", game_over, 1);

        // Long render spans two ticks: overrun, then exactly one move
        do_reset();
        g2_in_x = 5'd21; g2_in_y = 4'd10;
        key_dir = 4'b0001;
        frame("e_init", 1'b0, 1, 1);
        wait_rise(rc);
        chk("slow_px", bus.pl_game_x, 2);
        repeat (20) @(negedge clock);
        chk("slow_ovr", tick_overrun, 1);
        chk("slow_hold_px", bus.pl_game_x, 2);
        finish_render();
        frame("after_ovr", 1'b0, 3, 1);
        chk("ovr_sticky", tick_overrun, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
